// File: rtl/audio_pkg.sv
// Shared audio types: the signed sample format and the crossfader state encoding.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        PLAYING   = 2'd2,
        RAMP_DOWN = 2'd3
    } xfade_state_t;

    // True while the gain is moving in either direction.
    function automatic logic is_ramping(input xfade_state_t s);
        return (s == RAMP_UP) || (s == RAMP_DOWN);
    endfunction

endpackage

// File: rtl/gain_scaler.sv
// Two-stage scaler: capture sample and gain on the strobe, then register
// (sample * gain) >>> GAIN_BITS together with a one-cycle valid pulse.
module gain_scaler
    import audio_pkg::*;
#(
    parameter int GAIN_BITS = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 i_valid,
    input  logic [15:0]          i_sample,
    input  logic [GAIN_BITS:0]   i_gain,
    output logic [15:0]          o_audio,
    output logic                 o_valid
);

    localparam int PROD_W = 17 + GAIN_BITS;

    sample_t                   r_sample;
    logic [GAIN_BITS:0]        r_gain;
    logic                      r_valid;
    logic [15:0]               r_audio;
    logic                      r_valid_out;

    logic signed [PROD_W-1:0]  w_product;
    sample_t                   w_scaled;

    // Gain is unsigned, so a zero MSB is prepended before the signed multiply.
    assign w_product = r_sample * $signed({1'b0, r_gain});
    // Gain never exceeds unity, so the floor-shifted product always fits 16 bits.
    assign w_scaled  = sample_t'(w_product >>> GAIN_BITS);

    // Stage 1: hold the operands of the sample just strobed.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sample <= '0;
            r_gain   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sample <= sample_t'(i_sample);
                r_gain   <= i_gain;
            end
        end
    end

    // Stage 2: register the scaled result; output holds between pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_audio     <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= r_valid;
            if (r_valid) begin
                r_audio <= w_scaled;
            end
        end
    end

    assign o_audio = r_audio;
    assign o_valid = r_valid_out;

endmodule

// File: rtl/output_crossfader.sv
// Click-free source selector: ramps the active source to zero before switching
// and ramps the new source up, so no output sample ever mixes two sources.
module output_crossfader
    import audio_pkg::*;
#(
    parameter int GAIN_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        audio_trigger,
    input  logic [15:0] src_0,
    input  logic [15:0] src_1,
    input  logic [15:0] src_2,
    input  logic [15:0] src_3,
    input  logic [1:0]  src_sel,
    input  logic        mute_in,
    output logic [15:0] audio_out,
    output logic        audio_valid_out,
    output logic [1:0]  active_sel_out,
    output logic        busy_out
);

    localparam logic [GAIN_BITS:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GAIN_BITS:0] GAIN_ONE  = {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [GAIN_BITS:0] GAIN_ZERO = '0;

    xfade_state_t        r_state;
    logic [GAIN_BITS:0]  r_gain;
    logic [1:0]          r_active_sel;

    xfade_state_t        w_state_next;
    logic [GAIN_BITS:0]  w_gain_next;
    logic [1:0]          w_sel_next;
    logic                w_target_match;
    logic [15:0]         w_sample;

    // The request is satisfied when unmuted and already routing the wanted source.
    assign w_target_match = !mute_in && (src_sel == r_active_sel);

    // Next state, gain and routing; everything holds unless a strobe arrives.
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        w_sel_next   = r_active_sel;
        if (audio_trigger) begin
            case (r_state)
                MUTED: begin
                    if (!mute_in) begin
                        w_sel_next   = src_sel;
                        w_gain_next  = GAIN_ONE;
                        w_state_next = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!w_target_match) begin
                        if (r_gain == GAIN_ZERO) begin
                            // Still silent after a switch: retarget without going negative.
                            if (mute_in) begin
                                w_state_next = MUTED;
                            end else begin
                                w_sel_next  = src_sel;
                                w_gain_next = GAIN_ONE;
                            end
                        end else begin
                            w_gain_next  = r_gain - GAIN_ONE;
                            w_state_next = RAMP_DOWN;
                        end
                    end else begin
                        w_gain_next = r_gain + GAIN_ONE;
                        if (w_gain_next == GAIN_FULL) begin
                            w_state_next = PLAYING;
                        end
                    end
                end
                PLAYING: begin
                    if (!w_target_match) begin
                        w_gain_next  = r_gain - GAIN_ONE;
                        w_state_next = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (w_target_match) begin
                        // Request came back to the routed source: reverse in place.
                        w_gain_next  = r_gain + GAIN_ONE;
                        w_state_next = (w_gain_next == GAIN_FULL) ? PLAYING : RAMP_UP;
                    end else begin
                        w_gain_next = r_gain - GAIN_ONE;
                        if (w_gain_next == GAIN_ZERO) begin
                            if (mute_in) begin
                                w_state_next = MUTED;
                            end else begin
                                w_sel_next   = src_sel;
                                w_state_next = RAMP_UP;
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = MUTED;
                    w_gain_next  = GAIN_ZERO;
                end
            endcase
        end
    end

    // Sample is taken from the routing that applies after this strobe's update.
    always_comb begin
        w_sample = src_0;
        case (w_sel_next)
            2'd0:    w_sample = src_0;
            2'd1:    w_sample = src_1;
            2'd2:    w_sample = src_2;
            default: w_sample = src_3;
        endcase
    end

    // Crossfade FSM and gain counter registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= MUTED;
            r_gain       <= GAIN_ZERO;
            r_active_sel <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_gain       <= w_gain_next;
            r_active_sel <= w_sel_next;
        end
    end

    gain_scaler #(
        .GAIN_BITS (GAIN_BITS)
    ) u_gain_scaler (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_valid  (audio_trigger),
        .i_sample (w_sample),
        .i_gain   (w_gain_next),
        .o_audio  (audio_out),
        .o_valid  (audio_valid_out)
    );

    assign active_sel_out = r_active_sel;
    assign busy_out       = is_ramping(r_state);

endmodule

// File: tb/tb_output_crossfader.sv
// Directed bench for the crossfader: ramps, switches, reversal, mute and async reset.
module tb_output_crossfader;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        audio_trigger = 1'b0;
    logic [15:0] src_0 = '0;
    logic [15:0] src_1 = '0;
    logic [15:0] src_2 = '0;
    logic [15:0] src_3 = '0;
    logic [1:0]  src_sel = 2'd0;
    logic        mute_in = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid_out;
    logic [1:0]  active_sel_out;
    logic        busy_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int sample_v;

    output_crossfader #(
        .GAIN_BITS (6)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .audio_trigger   (audio_trigger),
        .src_0           (src_0),
        .src_1           (src_1),
        .src_2           (src_2),
        .src_3           (src_3),
        .src_sel         (src_sel),
        .mute_in         (mute_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .active_sel_out  (active_sel_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // floor(src * gain / 64) on a signed int
    function automatic int model(input int s, input int g);
        return (s * g) >>> 6;
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One strobe; result must appear exactly two edges later, pulse once, then hold.
    task automatic do_trigger(output int o);
        @(negedge clk_in);
        audio_trigger = 1'b1;
        @(posedge clk_in);
        #1 audio_trigger = 1'b0;
        @(posedge clk_in);
        #1;
        check("valid_pulse", int'(audio_valid_out), 1);
        o = int'($signed(audio_out));
        @(posedge clk_in);
        #1;
        check("valid_drop", int'(audio_valid_out), 0);
        repeat (3) @(posedge clk_in);
        #1;
        check("hold", int'($signed(audio_out)), o);
    endtask

    // n strobes with gains g0+step*1 .. g0+step*n; routing checked except at a reload.
    task automatic run_ramp(input string tag, input int s, input int g0, input int step,
                            input int n, input int act);
        int o;
        for (int i = 1; i <= n; i++) begin
            do_trigger(o);
            check(tag, o, model(s, g0 + step * i));
            $display("%s: trig %0d gain %0d out %0d sel %0d busy %0d", tag, i,
                     g0 + step * i, o, active_sel_out, busy_out);
            if (!(step < 0 && i == n))
                check({tag, "_sel"}, int'(active_sel_out), act);
        end
    endtask

    initial begin
        // Scenario 1: reset state, then ramp up source 0
        src_0 = 16'd1000;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_out", int'(audio_out), 0);
        check("rst_valid", int'(audio_valid_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_sel", int'(active_sel_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        do_trigger(sample_v);
        check("s1_k1", sample_v, 15);
        check("s1_busy_k1", int'(busy_out), 1);
        do_trigger(sample_v);
        check("s1_k2", sample_v, 31);
        do_trigger(sample_v);
        check("s1_k3", sample_v, 46);
        run_ramp("s1_up", 1000, 3, 1, 61, 0);
        check("s1_final", int'($signed(audio_out)), 1000);
        check("s1_busy_end", int'(busy_out), 0);

        // Scenario 2: switch 0 -> 2, full down then full up
        src_2 = 16'hF830; // -2000
        src_sel = 2'd2;
        run_ramp("s2_down", 1000, 64, -1, 64, 0);
        check("s2_sel_switched", int'(active_sel_out), 2);
        do_trigger(sample_v);
        check("s2_k1", sample_v, -32);
        do_trigger(sample_v);
        check("s2_k2", sample_v, -63);
        run_ramp("s2_up", -2000, 2, 1, 62, 2);
        check("s2_final", int'($signed(audio_out)), -2000);
        check("s2_busy_end", int'(busy_out), 0);

        // Scenario 3: interrupt a ramp-up at gain 20
        src_1 = 16'hFC18; // -1000
        src_sel = 2'd1;
        run_ramp("s3_down", -2000, 64, -1, 64, 2);
        do_trigger(sample_v);
        check("s3_neg_floor", sample_v, -16);
        run_ramp("s3_up", -1000, 1, 1, 19, 1);
        src_3 = 16'd500;
        src_sel = 2'd3;
        run_ramp("s3_abort", -1000, 20, -1, 20, 1);
        check("s3_sel_switched", int'(active_sel_out), 3);
        do_trigger(sample_v);
        check("s3_new_k1", sample_v, 7);
        run_ramp("s3_new_up", 500, 1, 1, 63, 3);
        check("s3_busy_end", int'(busy_out), 0);

        // Scenario 4: reversal in RAMP_DOWN at gain 30
        src_sel = 2'd0;
        run_ramp("s4_down", 500, 64, -1, 34, 3);
        check("s4_busy_down", int'(busy_out), 1);
        src_sel = 2'd3;
        run_ramp("s4_rev", 500, 30, 1, 34, 3);
        check("s4_busy_end", int'(busy_out), 0);

        // Scenario 5: mute and unmute
        mute_in = 1'b1;
        run_ramp("s5_mute", 500, 64, -1, 64, 3);
        check("s5_busy_muted", int'(busy_out), 0);
        check("s5_sel_muted", int'(active_sel_out), 3);
        run_ramp("s5_silent", 500, 0, 0, 3, 3);
        mute_in = 1'b0;
        run_ramp("s5_unmute", 500, 0, 1, 10, 3);
        check("s5_busy_up", int'(busy_out), 1);

        // Scenario 6: async reset between edges mid-ramp
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1;
        check("s6_rst_out", int'(audio_out), 0);
        check("s6_rst_busy", int'(busy_out), 0);
        check("s6_rst_sel", int'(active_sel_out), 0);
        check("s6_rst_valid", int'(audio_valid_out), 0);
        src_sel = 2'd0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        run_ramp("s6_up", 1000, 0, 1, 64, 0);
        check("s6_final", int'($signed(audio_out)), 1000);
        check("s6_busy_end", int'(busy_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/output_crossfader.md
# output_crossfader

Click-free source selector between the audio sources (test tone, raw/filtered mic, delayed, convolved) and the `pdm` stage. It holds one active 16-bit signed source and applies a linear gain ramp at 48 kHz sample rate. On a source change or mute it ramps the active source down to zero, switches, and ramps the new source up. Its registered output feeds `pdm.level_in` directly.

## Interface
- `GAIN_BITS`, default 6: ramp resolution. Gain runs 0..2^GAIN_BITS; a full ramp takes 2^GAIN_BITS samples (64 samples ≈ 1.33 ms).
- `clk_in` in, 1: audio clock, 98.3 MHz.
- `rst_in` in, 1: reset, asynchronous, active-low.
- `audio_trigger` in, 1: one-cycle 48 kHz sample strobe.
- `src_0`..`src_3` in, 16 each: signed sources, sampled on `audio_trigger`.
- `src_sel` in, 2: requested source, level-sensitive.
- `mute_in` in, 1: when high, ramp to silence and hold.
- `audio_out` out, 16: signed scaled sample, registered.
- `audio_valid_out` out, 1: one-cycle pulse when `audio_out` updates.
- `active_sel_out` out, 2: source currently routed.
- `busy_out` out, 1: high while ramping.

## Operation
- States:
  - MUTED: gain 0.
  - RAMP_UP: gain +1 per trigger.
  - PLAYING: gain is 2^GAIN_BITS.
  - RAMP_DOWN: gain −1 per trigger.
- Gain and state change only on cycles where `audio_trigger` is high. Input requests are evaluated on the same trigger.
- Target is `src_sel` when `mute_in` is low, otherwise "silence".
- MUTED:
  - If `mute_in` is low, latch `active_sel` ← `src_sel` and go to RAMP_UP.
  - Gain becomes 1 on that same trigger.
- RAMP_UP:
  - If the target differs from `active_sel`, or mute is set, go to RAMP_DOWN from the current gain. There is no jump.
  - Otherwise increment gain. On reaching 2^GAIN_BITS, go to PLAYING.
- PLAYING: a target change or mute goes to RAMP_DOWN, and gain decrements on that trigger.
- RAMP_DOWN:
  - Decrement gain.
  - If the target becomes the current `active_sel` again and mute is low, reverse to RAMP_UP from the current gain. `active_sel` is unchanged.
  - When gain reaches 0:
    - If muted, go to MUTED.
    - Otherwise load `active_sel` ← `src_sel` and go to RAMP_UP. The next trigger gives gain 1.
- `src_sel` changes during RAMP_DOWN only update the pending target; the ramp continues.
- Arithmetic:
  - Product = signed 16 × unsigned (GAIN_BITS+1), giving a (17+GAIN_BITS)-bit signed result.
  - `audio_out` = product >>> GAIN_BITS. This is an arithmetic, floor shift.
  - Because gain ≤ 1.0, there is no overflow and no saturation is needed. Width is truncated to 16.
- A sample is never formed from a mix of two sources.
- `busy_out` = state is RAMP_UP or RAMP_DOWN.

## Timing
- Reset values:
  - state MUTED, gain 0, `active_sel_out` 0.
  - `audio_out` 0, `audio_valid_out` 0, `busy_out` 0.
  - Registers clear immediately on a `rst_in` falling edge, with no clock needed.
- Pipeline:
  - Cycle T: `audio_trigger` is high. The selected source sample and the updated gain are registered.
  - Cycle T+1: multiply.
  - Cycle T+2: `audio_out` is registered and `audio_valid_out` pulses.
  - Latency is 2 clocks.
- The gain used for the sample captured at T is the gain after the T update.
- `audio_out` holds between pulses.
- A trigger arriving while the pipeline is busy is impossible, since triggers are 2048 clocks apart. No backpressure.
- Reset released mid-sequence restarts from MUTED. With `mute_in` low, the first trigger starts RAMP_UP on `src_sel`.

## Structure
- Shared `audio_pkg`:
  - `typedef logic signed [15:0] sample_t`
  - `xfade_state_t` enum {MUTED, RAMP_UP, PLAYING, RAMP_DOWN}
- One sub-module, `gain_scaler`: a 2-stage registered multiply-and-shift with the valid pipeline. The FSM and gain counter stay in the top of `output_crossfader`.

## Test plan
All tests use `GAIN_BITS`=6.
1. Reset release, `mute_in`=0, `src_sel`=0, `src_0`=1000 → successive outputs (1000·k)>>>6: 15, 31, 46 … 1000 at the 64th trigger. `busy_out` falls at that trigger; PLAYING.
2. From PLAYING, `src_sel` 0→2 with `src_2`=−2000:
   - 64 descending outputs of source 0, ending at 0.
   - Then `active_sel_out`=2 and outputs (−2000·k)>>>6: −32, −63 … −2000.
   - 128 triggers total; no output sample mixes sources.
3. Ramp up to gain 20, then change `src_sel` → next outputs use gains 19, 18 … 0, then the new source ramps from 1. Negative floor check: `src`=−1000 at gain 1 gives −16.
4. In RAMP_DOWN at gain 30, return `src_sel` to the active source → gain 31, 32 … 64. `active_sel_out` never changes.
5. Assert `mute_in` in PLAYING → ramp to 0, state MUTED, `audio_out` stays 0 and `audio_valid_out` keeps pulsing. Deassert → ramp up from 1.
6. Drive `rst_in` low asynchronously mid-ramp, between clock edges → `audio_out`=0, `busy_out`=0, `active_sel_out`=0 immediately. After release, behaviour matches scenario 1.
